// File: rtl/pong_pixel_engine.sv
// Single-player Pong pixel source for the VGA controller: frame-tick game state plus 1-cycle registered RGB.
// Optional build macro PONG_AUTO_SERVE_EN: SERVE launches by itself on the 30th frame tick.
module pong_pixel_engine #(
  parameter int X_START     = 144,
  parameter int Y_START     = 34,
  parameter int BALL_SIZE   = 8,
  parameter int BALL_SPEED  = 2,
  parameter int PADDLE_X    = 616,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE_H    = 64,
  parameter int BORDER      = 4,
  parameter int MISS_FRAMES = 60
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [11:0] iVGA_X,
  input  logic [11:0] iVGA_Y,
  input  logic        iVGA_V_SYNC,
  input  logic [9:0]  iPADDLE_Y,
  input  logic        iSERVE,
  output logic [9:0]  oRed,
  output logic [9:0]  oGreen,
  output logic [9:0]  oBlue,
  output logic [7:0]  oMISSES,
  output logic [7:0]  oHITS,
  output logic [1:0]  oSTATE
);

  localparam int H_VIS   = 640;
  localparam int V_VIS   = 480;
  localparam int PAD_MAX = V_VIS - BORDER - PADDLE_H;
  localparam logic [9:0] CX = 10'((H_VIS - BALL_SIZE) / 2);
  localparam logic [9:0] CY = 10'((V_VIS - BALL_SIZE) / 2);
  localparam logic signed [11:0] S_HVIS = 12'(H_VIS);
  localparam logic signed [11:0] S_VVIS = 12'(V_VIS);
  localparam logic signed [11:0] S_PADX = 12'(PADDLE_X);
  localparam logic signed [11:0] S_PADW = 12'(PADDLE_W);
  localparam logic signed [11:0] S_PADH = 12'(PADDLE_H);
  localparam logic signed [11:0] S_BALL = 12'(BALL_SIZE);
  localparam logic signed [11:0] S_BRD  = 12'(BORDER);
`ifdef PONG_AUTO_SERVE_EN
  localparam int AUTO_FRAMES = 30;
`endif

  typedef enum logic [1:0] {ST_SERVE = 2'd0, ST_PLAY = 2'd1, ST_MISS = 2'd2} state_t;

  state_t      r_state, w_state_nxt;
  logic [9:0]  r_bx, r_by, r_pad_y, w_bx_nxt, w_by_nxt, w_pad_nxt;
  logic        r_dx_neg, r_dy_neg, w_dxn_nxt, w_dyn_nxt;
  logic [7:0]  r_cnt, r_hits, r_misses, w_cnt_nxt, w_hits_nxt, w_misses_nxt;
  logic        r_vs_prev;
  logic        w_tick, w_overlap, w_hit, w_miss;
  logic [10:0] w_bx_far, w_by_far;
  logic [9:0]  r_red_p1, r_green_p1, r_blue_p1, w_red, w_green, w_blue;
  logic signed [11:0] w_px, w_py, w_bx_s, w_by_s, w_pad_s;
  logic        w_vis, w_on_ball, w_on_pad, w_on_border;

  function automatic logic [9:0] clamp_pad(input logic [9:0] y);
    if (y < 10'(BORDER))       return 10'(BORDER);
    else if (y > 10'(PAD_MAX)) return 10'(PAD_MAX);
    else                       return y;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef PONG_AUTO_SERVE_EN
  logic w_unused_serve;
  assign w_unused_serve = iSERVE;
`endif

  assign w_tick    = iVGA_V_SYNC & ~r_vs_prev;
  assign w_bx_far  = {1'b0, r_bx} + 11'(BALL_SIZE + BALL_SPEED);
  assign w_by_far  = {1'b0, r_by} + 11'(BALL_SIZE + BALL_SPEED);
  // Collision uses the paddle as currently displayed, so the ball bounces off what the player sees
  assign w_overlap = ({1'b0, r_by} + 11'(BALL_SIZE) > {1'b0, r_pad_y}) &&
                     ({1'b0, r_by} < {1'b0, r_pad_y} + 11'(PADDLE_H));
  assign w_hit     = !r_dx_neg && (w_bx_far >= 11'(PADDLE_X)) && w_overlap;
  assign w_miss    = !r_dx_neg && (w_bx_far >= 11'(H_VIS)) && !w_overlap;

  // State register: game state only moves on the frame tick
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state   <= ST_SERVE;
      r_bx      <= CX;
      r_by      <= CY;
      r_dx_neg  <= 1'b0;
      r_dy_neg  <= 1'b0;
      r_pad_y   <= 10'd208;
      r_cnt     <= '0;
      r_hits    <= '0;
      r_misses  <= '0;
      r_vs_prev <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bx      <= w_bx_nxt;
      r_by      <= w_by_nxt;
      r_dx_neg  <= w_dxn_nxt;
      r_dy_neg  <= w_dyn_nxt;
      r_pad_y   <= w_pad_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hits    <= w_hits_nxt;
      r_misses  <= w_misses_nxt;
      r_vs_prev <= iVGA_V_SYNC;
    end
  end

  // Next-state and per-frame ball/paddle update
  always_comb begin
    w_state_nxt  = r_state;
    w_bx_nxt     = r_bx;
    w_by_nxt     = r_by;
    w_dxn_nxt    = r_dx_neg;
    w_dyn_nxt    = r_dy_neg;
    w_pad_nxt    = r_pad_y;
    w_cnt_nxt    = r_cnt;
    w_hits_nxt   = r_hits;
    w_misses_nxt = r_misses;
    if (w_tick) begin
      w_pad_nxt = clamp_pad(iPADDLE_Y);
      case (r_state)
        ST_SERVE: begin
`ifdef PONG_AUTO_SERVE_EN
          if (r_cnt == 8'(AUTO_FRAMES - 1)) begin
            w_state_nxt = ST_PLAY;
            w_dxn_nxt   = 1'b0;
            w_dyn_nxt   = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
`else
          if (iSERVE) begin
            w_state_nxt = ST_PLAY;
            w_dxn_nxt   = 1'b0;
            w_dyn_nxt   = 1'b0;
          end
`endif
        end
        ST_PLAY: begin
          if (w_hit) begin
            w_bx_nxt   = 10'(PADDLE_X - BALL_SIZE);
            w_dxn_nxt  = 1'b1;
            w_hits_nxt = r_hits + 8'd1;
          end else if (w_miss) begin
            w_state_nxt  = ST_MISS;
            w_misses_nxt = sat_inc(r_misses);
            w_cnt_nxt    = '0;
          end else if (r_dx_neg && (r_bx <= 10'(BORDER + BALL_SPEED))) begin
            w_bx_nxt  = 10'(BORDER);
            w_dxn_nxt = 1'b0;
          end else begin
            w_bx_nxt = r_dx_neg ? r_bx - 10'(BALL_SPEED) : r_bx + 10'(BALL_SPEED);
          end
          if (r_dy_neg && (r_by <= 10'(BORDER + BALL_SPEED))) begin
            w_by_nxt  = 10'(BORDER);
            w_dyn_nxt = 1'b0;
          end else if (!r_dy_neg && (w_by_far >= 11'(V_VIS - BORDER))) begin
            w_by_nxt  = 10'(V_VIS - BORDER - BALL_SIZE);
            w_dyn_nxt = 1'b1;
          end else begin
            w_by_nxt = r_dy_neg ? r_by - 10'(BALL_SPEED) : r_by + 10'(BALL_SPEED);
          end
        end
        ST_MISS: begin
          if (r_cnt == 8'(MISS_FRAMES - 1)) begin
            w_state_nxt = ST_SERVE;
            w_bx_nxt    = CX;
            w_by_nxt    = CY;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
        default: w_state_nxt = ST_SERVE;
      endcase
    end
  end

  // Render stage p0: +1 on X so the registered pixel lines up with the controller's gating
  assign w_px    = $signed(iVGA_X + 12'd1 - 12'(X_START));
  assign w_py    = $signed(iVGA_Y - 12'(Y_START));
  assign w_bx_s  = $signed({2'b00, r_bx});
  assign w_by_s  = $signed({2'b00, r_by});
  assign w_pad_s = $signed({2'b00, r_pad_y});

  assign w_vis       = (w_px >= 12'sd0) && (w_px < S_HVIS) && (w_py >= 12'sd0) && (w_py < S_VVIS);
  assign w_on_ball   = (w_px >= w_bx_s) && (w_px < w_bx_s + S_BALL) &&
                       (w_py >= w_by_s) && (w_py < w_by_s + S_BALL);
  assign w_on_pad    = (w_px >= S_PADX) && (w_px < S_PADX + S_PADW) &&
                       (w_py >= w_pad_s) && (w_py < w_pad_s + S_PADH);
  assign w_on_border = (w_py < S_BRD) || (w_py >= S_VVIS - S_BRD) || (w_px < S_BRD);

  always_comb begin
    w_red   = '0;
    w_green = '0;
    w_blue  = '0;
    if (w_vis) begin
      if (w_on_ball) begin
        w_red = 10'h3FF;
        if (r_state != ST_MISS) begin
          w_green = 10'h3FF;
          w_blue  = 10'h3FF;
        end
      end else if (w_on_pad) begin
        w_green = 10'h3FF;
      end else if (w_on_border) begin
        w_red   = 10'h200;
        w_green = 10'h200;
        w_blue  = 10'h200;
      end
    end
  end

  // Render stage p1: registered colour, black from the cycle after reset
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_red_p1   <= '0;
      r_green_p1 <= '0;
      r_blue_p1  <= '0;
    end else begin
      r_red_p1   <= w_red;
      r_green_p1 <= w_green;
      r_blue_p1  <= w_blue;
    end
  end

  assign oRed    = r_red_p1;
  assign oGreen  = r_green_p1;
  assign oBlue   = r_blue_p1;
  assign oMISSES = r_misses;
  assign oHITS   = r_hits;
  assign oSTATE  = r_state;

endmodule

// File: tb/tb_pong_pixel_engine.sv
// Randomised bench for pong_pixel_engine: frame ticks are driven directly on V_SYNC and
// each tick is scored against an integer game model; pixels are probed at chosen raw coordinates.
module tb_pong_pixel_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] vga_x, vga_y;
  logic        vsync;
  logic [9:0]  pad_in;
  logic        serve;
  logic [9:0]  red, green, blue;
  logic [7:0]  misses, hits;
  logic [1:0]  state;

  int n_chk  = 0;
  int n_fail = 0;

  // Game model
  int m_state, m_bx, m_by, m_dx, m_dy, m_pad, m_hits, m_misses, m_cnt;

  localparam logic [29:0] WHITE = {10'h3FF, 10'h3FF, 10'h3FF};
  localparam logic [29:0] REDC  = {10'h3FF, 10'h000, 10'h000};
  localparam logic [29:0] GREEN = {10'h000, 10'h3FF, 10'h000};
  localparam logic [29:0] GREY  = {10'h200, 10'h200, 10'h200};

  always #5 clk = ~clk;

  pong_pixel_engine dut (
    .iCLK(clk), .iRST(rst), .iVGA_X(vga_x), .iVGA_Y(vga_y), .iVGA_V_SYNC(vsync),
    .iPADDLE_Y(pad_in), .iSERVE(serve), .oRed(red), .oGreen(green), .oBlue(blue),
    .oMISSES(misses), .oHITS(hits), .oSTATE(state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
    m_pad = 208; m_hits = 0; m_misses = 0; m_cnt = 0;
  endtask

  function automatic int clampi(input int v);
    if (v < 4)   return 4;
    if (v > 412) return 412;
    return v;
  endfunction

  task automatic model_tick(input bit sv, input int pin);
    bit overlap;
    case (m_state)
      0: begin
`ifdef PONG_AUTO_SERVE_EN
        if (m_cnt == 29) begin m_state = 1; m_dx = 1; m_dy = 1; end
        else m_cnt++;
`else
        if (sv) begin m_state = 1; m_dx = 1; m_dy = 1; end
`endif
      end
      1: begin
        overlap = (m_by + 8 > m_pad) && (m_by < m_pad + 64);
        if (m_dx > 0 && m_bx + 10 >= 616 && overlap) begin
          m_bx = 608; m_dx = -1; m_hits = (m_hits + 1) % 256;
        end else if (m_dx > 0 && m_bx + 10 >= 640) begin
          m_state = 2; m_cnt = 0; if (m_misses < 255) m_misses++;
        end else if (m_dx < 0 && m_bx <= 6) begin
          m_bx = 4; m_dx = 1;
        end else m_bx += 2 * m_dx;
        if (m_dy < 0 && m_by <= 6) begin m_by = 4; m_dy = 1; end
        else if (m_dy > 0 && m_by + 10 >= 476) begin m_by = 468; m_dy = -1; end
        else m_by += 2 * m_dy;
      end
      default: begin
        if (m_cnt == 59) begin m_state = 0; m_bx = 316; m_by = 236; m_cnt = 0; end
        else m_cnt++;
      end
    endcase
    m_pad = clampi(pin);
  endtask

  function automatic logic [29:0] model_pix(input int x, input int y);
    int px, py;
    px = x + 1 - 144;
    py = y - 34;
    if (px < 0 || px >= 640 || py < 0 || py >= 480) return 30'd0;
    if (px >= m_bx && px < m_bx + 8 && py >= m_by && py < m_by + 8)
      return (m_state == 2) ? REDC : WHITE;
    if (px >= 616 && px < 624 && py >= m_pad && py < m_pad + 64) return GREEN;
    if (py < 4 || py >= 476 || px < 4) return GREY;
    return 30'd0;
  endfunction

  task automatic tick(input bit sv, input int pin);
    serve  = sv;
    pad_in = 10'(pin);
    vsync  = 1'b0;
    step();
    vsync  = 1'b1;
    step();
    model_tick(sv, pin);
    chk("state", 32'(state), 32'(m_state));
    chk("hits", 32'(hits), 32'(m_hits));
    chk("misses", 32'(misses), 32'(m_misses));
  endtask

  task automatic probe_raw(input string tag, input int x, input int y);
    vga_x = 12'(x);
    vga_y = 12'(y);
    step();
    chk(tag, 32'({red, green, blue}), 32'(model_pix(x, y)));
  endtask

  task automatic probe(input string tag, input int lx, input int ly);
    probe_raw(tag, lx + 143, ly + 34);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    chk("rst_rgb", 32'({red, green, blue}), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_hits", 32'(hits), 32'd0);
    chk("rst_misses", 32'(misses), 32'd0);
    vsync = 1'b0;
    step();
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int p;
    rst = 1'b1; vga_x = '0; vga_y = '0; vsync = 1'b0; pad_in = 10'd208; serve = 1'b0;
    repeat (3) step();
    do_reset();

    // Idle in SERVE, centred ball, border and background
    repeat (3) tick(1'b0, 208);
    chk("serve_hold", 32'(state), 32'd0);
    probe("ball_tl", 316, 236);
    probe("ball_br", 323, 243);
    probe("ball_out", 324, 243);
    vga_x = 12'd143; vga_y = 12'd34; step();
    chk("px0_grey", 32'({red, green, blue}), 32'(GREY));
    probe("bg", 320, 100);
    probe("pad0", 616, 208);
    probe("offscreen", -1, 10);

    // Launch and ten frames of flight
    for (int i = 0; i < 40 && m_state != 1; i++) tick(1'b1, 208);
    chk("launched", 32'(state), 32'd1);
    repeat (10) tick(1'b0, 208);
    vga_x = 12'(336 + 143); vga_y = 12'(256 + 34); step();
    chk("ball10", 32'({red, green, blue}), 32'(WHITE));
    probe("ball10_l", 335, 256);

    // Paddle clamp at the bottom
    tick(1'b0, 1000);
    vga_x = 12'(616 + 143); vga_y = 12'(412 + 34); step();
    chk("clamp_top", 32'({red, green, blue}), 32'(GREEN));
    probe("clamp_above", 616, 411);
    tick(1'b0, 0);
    probe("clamp_low", 616, 4);

    // Random play: paddle mostly tracks the ball so both hits and misses occur
    for (int i = 0; i < 1200; i++) begin
      if ($urandom % 3 == 0) p = int'($urandom % 1024);
      else begin
        p = m_by - 28 + int'($urandom % 41) - 20;
        if (p < 0) p = 0;
      end
      tick(($urandom % 4) == 0, p);
      probe("r_ball_tl", m_bx, m_by);
      probe("r_ball_br", m_bx + 7, m_by + 7);
      probe("r_ball_nx", m_bx + 8, m_by);
      probe("r_pad", 616 + int'($urandom % 8), m_pad + int'($urandom % 64));
      probe_raw("r_any", int'($urandom % 900), int'($urandom % 600));
    end

    // Reset in the middle of a line while playing
    for (int i = 0; i < 80 && m_state != 1; i++) tick(1'b1, 208);
    chk("pre_rst_play", 32'(state), 32'd1);
    probe("pre_rst_ball", m_bx, m_by);
    do_reset();
    probe("post_rst_ball", 316, 236);

`ifdef PONG_AUTO_SERVE_EN
    repeat (29) tick(1'b0, 208);
    chk("auto_wait", 32'(state), 32'd0);
    tick(1'b0, 208);
    chk("auto_launch", 32'(state), 32'd1);
`else
    repeat (40) tick(1'b0, 208);
    chk("no_auto", 32'(state), 32'd0);
    tick(1'b1, 208);
    chk("manual_launch", 32'(state), 32'd1);
`endif
    tick(1'b0, 208);
    probe("final_ball", m_bx, m_by);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
